wb2apb_bridge: RTL and testbench
================================

Name: wb2apb_bridge

Overview:
Wishbone classic slave to APB4 master bridge. Sits directly upstream of the team's APB slave/memory block and drives its psel/penable/paddr/pwrite/pwdata/pstrb while consuming pready/prdata/pslverr. Converts one Wishbone cycle into exactly one APB transfer, with no pipelining and at most one outstanding transfer. Adds a misaligned-address check and a pready timeout, so the Wishbone master never hangs.

Parameters:
ADDR_W, 32, width of wb_adr_i and paddr (byte address)
DATA_W, 32, data width; fixed at 32 (pstrb is 4 bits)
TIMEOUT, 16, max ACCESS cycles waiting for pready before aborting with error; 0 disables the timeout

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
wb_cyc_i  in  1  Wishbone cycle valid
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  1 = write
wb_adr_i  in  ADDR_W  byte address
wb_dat_i  in  DATA_W  write data
wb_sel_i  in  4  byte selects
wb_dat_o  out  DATA_W  read data, valid with wb_ack_o
wb_ack_o  out  1  one-cycle success termination
wb_err_o  out  1  one-cycle error termination
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pstrb  out  4  APB write strobes
pready  in  1  APB ready
prdata  in  DATA_W  APB read data
pslverr  in  1  APB slave error

Behaviour:
- Reset (async, rst=1): state IDLE; psel, penable, pwrite, wb_ack_o, wb_err_o = 0; paddr, pwdata, wb_dat_o = 0; pstrb = 0; timeout counter = 0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - When wb_cyc_i & wb_stb_i are high and wb_ack_o/wb_err_o are low, latch adr, we, dat and sel.
  - If adr[1:0] != 0: go to RESP with error; no APB activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pwdata driven from the latches.
  - pstrb = sel on writes, 4'b0000 on reads (APB4 rule).
  - Always proceeds to ACCESS.
- ACCESS: psel=1, penable=1. Address, control and data stay stable until pready is sampled high.
  - pready=1: capture prdata (reads only) and pslverr, then go to RESP. psel and penable drop in the same transition.
  - pready=0: increment the timeout counter. When the counter reaches TIMEOUT-1 (TIMEOUT>0), drop psel/penable and go to RESP with error.
- RESP (1 cycle):
  - wb_ack_o=1 if there was no error; wb_err_o=1 if pslverr, timeout or misalignment occurred. Never both.
  - wb_dat_o = captured prdata on a successful read, otherwise 0.
  - Returns to IDLE. Response strobes are cleared on the next cycle.
  - A new request is accepted in IDLE only, so back-to-back transfers take at least 4 cycles each.
- Latency, with the request sampled at edge E0:
  - SETUP after E0, ACCESS after E1.
  - A zero-wait slave (pready high in the first ACCESS cycle) gives wb_ack_o high after E2.
  - Our registered APB slave raises pready one cycle late, which gives ack after E3.
- wb_cyc_i dropped while in SETUP/ACCESS:
  - The APB transfer still completes, because APB cannot be aborted.
  - RESP still occurs, but wb_ack_o/wb_err_o are suppressed (held 0).
  - wb_dat_o is not updated.
- pready high during SETUP: ignored.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at their reset values. The APB slave sees psel drop.
- Timeout counter clears on every entry to SETUP. Width is the clog2 of TIMEOUT, minimum 1 bit.

Decomposition:
- Package wb2apb_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP)
  - response enum (RSP_OK, RSP_SLVERR, RSP_TIMEOUT, RSP_MISALIGN)
  - localparam STRB_W = 4
- One sub-module, wb2apb_timeout: loadable counter with clear, enable and an expired flag, parameterised by TIMEOUT. TIMEOUT=0 ties expired to 0.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, sel=4'hF, with the registered APB slave → psel rises 1 cycle after the request; penable 1 cycle later; pwrite=1, pstrb=4'hF; wb_ack_o pulses one cycle, 4 edges after the request; wb_err_o stays 0.
- Read 0x0000_0010 after the write above → pstrb=4'h0 and pwrite=0 during the transfer; wb_dat_o=0xDEADBEEF with wb_ack_o.
- Slave returns pready=1 with pslverr=1 on a read of 0x20 → wb_err_o pulses one cycle, wb_ack_o=0, wb_dat_o=0.
- TIMEOUT=16, slave holds pready=0 → psel/penable drop after 16 ACCESS cycles; wb_err_o pulses once; FSM returns to IDLE and the next request is accepted.
- Address 0x0000_0013 → wb_err_o pulses 1 cycle after the request; psel never asserted.
- Misc boundaries:
  - wb_cyc_i dropped in ACCESS → transfer completes with no ack/err.
  - rst asserted during ACCESS → psel=penable=0 immediately, without waiting for a clock edge; bridge is idle and accepts a new write after rst deasserts.

Source files
------------

// File: rtl/wb2apb_pkg.sv
// Shared types for the Wishbone-classic to APB4 bridge.
package wb2apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef enum logic [1:0] {RSP_OK, RSP_SLVERR, RSP_TIMEOUT, RSP_MISALIGN} rsp_t;

    localparam int STRB_W = 4;

endpackage

// File: rtl/wb2apb_timeout.sv
// ACCESS-phase wait counter: cleared on SETUP entry and flags the last allowed wait cycle.
module wb2apb_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_on
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
            assign expired = (count == LAST);
        end else begin : g_off
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wb2apb_bridge.sv
// Wishbone classic slave to APB4 master: one Wishbone cycle becomes exactly one APB transfer,
// with misaligned-address rejection and a pready timeout. All outputs are registered.
module wb2apb_bridge
    import wb2apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic [STRB_W-1:0] wb_sel_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr,
    output state_t            dbg_state
);

    // Handshakes: a Wishbone request is cyc&stb while neither ack nor err is showing; each
    // accepted request ends in exactly one single-cycle ack or err, unless cyc drops mid-transfer.
    // On APB, psel/paddr/pwrite/pwdata/pstrb stay stable through ACCESS until pready is sampled high.
    state_t state;
    logic   aborted;
    logic   req;
    logic   cyc_lost;
    logic   to_clr;
    logic   to_en;
    logic   to_expired;
    rsp_t   acc_rsp;

    assign req       = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
    assign cyc_lost  = aborted || !wb_cyc_i;
    assign to_clr    = (state == IDLE) && req;
    assign to_en     = (state == ACCESS) && !pready;
    assign dbg_state = state;

    always_comb begin
        acc_rsp = RSP_OK;
        if (pready) begin
            acc_rsp = pslverr ? RSP_SLVERR : RSP_OK;
        end else if (to_expired) begin
            acc_rsp = RSP_TIMEOUT;
        end
    end

    wb2apb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            aborted  <= 1'b0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            pstrb    <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        aborted <= 1'b0;
                        if (wb_adr_i[1:0] != 2'b00) begin
                            // Misaligned: answer straight away, the APB side never sees it.
                            wb_err_o <= 1'b1;
                            wb_dat_o <= '0;
                            state    <= RESP;
                        end else begin
                            psel   <= 1'b1;
                            paddr  <= wb_adr_i;
                            pwrite <= wb_we_i;
                            pwdata <= wb_dat_i;
                            pstrb  <= wb_we_i ? wb_sel_i : '0;
                            state  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    if (!wb_cyc_i) aborted <= 1'b1;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (!wb_cyc_i) aborted <= 1'b1;
                    if (pready || to_expired) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= RESP;
                        // An abandoned cycle still finishes on APB but reports nothing upstream.
                        if (!cyc_lost) begin
                            wb_ack_o <= (acc_rsp == RSP_OK);
                            wb_err_o <= (acc_rsp != RSP_OK);
                            wb_dat_o <= (acc_rsp == RSP_OK && !pwrite) ? prdata : '0;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb2apb_bridge.sv
// Bench for wb2apb_bridge: registered APB slave model, Wishbone driver and response scoreboard.
module tb_wb2apb_bridge;
    import wb2apb_pkg::*;

    localparam int W = 34;

    logic        clk;
    logic        rst;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    state_t      dbg_state;

    logic        slv_fast;
    logic        slv_stall;
    logic        slv_err;
    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    wb2apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // APB slave: normally registered (pready one cycle into ACCESS); fast mode holds pready high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (slv_fast) begin
            pready  <= 1'b1;
            pslverr <= slv_err;
            if (psel && !penable && !pwrite) prdata <= mem[paddr[7:2]];
            if (psel && penable && pwrite) begin
                for (int b = 0; b < 4; b++)
                    if (pstrb[b]) mem[paddr[7:2]][8*b +: 8] <= pwdata[8*b +: 8];
            end
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            if (psel && penable && !pready && !slv_stall) begin
                pready  <= 1'b1;
                pslverr <= slv_err;
                if (pwrite) begin
                    for (int b = 0; b < 4; b++)
                        if (pstrb[b]) mem[paddr[7:2]][8*b +: 8] <= pwdata[8*b +: 8];
                end else begin
                    prdata <= mem[paddr[7:2]];
                end
            end
        end
    end

    // Driver: one Wishbone cycle; the response is popped from exp_q and compared when it appears.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat, output int psel_n,
                           output int pen_n, output logic [3:0] strb_seen, output logic wr_seen);
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        lat = 0; psel_n = 0; pen_n = 0; strb_seen = '0; wr_seen = 1'b0;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        do begin
            @(negedge clk);
            lat++;
            if (psel) begin
                psel_n++;
                strb_seen = strb_seen | pstrb;
                wr_seen   = wr_seen | pwrite;
            end
            if (penable) pen_n++;
        end while (!wb_ack_o && !wb_err_o && lat < 100);
        got_v = {wb_err_o, wb_ack_o, wb_dat_o};
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if (!got_v[32] && !got_v[33]) begin
            failures++;
            $display("FAIL sb_no_response adr=%h waited=%0d cycles", adr, lat);
        end else if (got_v !== exp_v) begin
            failures++;
            $display("FAIL sb_response adr=%h got err/ack/dat=%b/%b/%h exp=%b/%b/%h", adr,
                     got_v[33], got_v[32], got_v[31:0], exp_v[33], exp_v[32], exp_v[31:0]);
        end
        @(negedge clk);
        checks++;
        if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
            failures++;
            $display("FAIL resp_one_cycle adr=%h ack=%b err=%b exp 0/0", adr, wb_ack_o, wb_err_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        slv_fast = 1'b0; slv_stall = 1'b0; slv_err = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_apb_ctl psel=%b penable=%b pwrite=%b exp 0", psel, penable, pwrite);
        end
        checks++;
        if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0) begin
            failures++;
            $display("FAIL reset_apb_data paddr=%h pwdata=%h pstrb=%h exp 0", paddr, pwdata, pstrb);
        end
        checks++;
        if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_wb ack=%b err=%b dat=%h exp 0", wb_ack_o, wb_err_o, wb_dat_o);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (psel !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL post_reset_idle psel=%b state=%0d exp 0/%0d", psel, dbg_state, IDLE);
        end
    endtask

    task automatic test_write();
        int lat, ps, pe;
        logic [3:0] st;
        logic wr;
        exp_q.push_back({2'b01, 32'h0});
        ref_mem[4] = 32'hDEADBEEF;
        wb_xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, lat, ps, pe, st, wr);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL write_latency got=%0d exp=4", lat); end
        checks++;
        if (ps != 3 || pe != 2) begin
            failures++;
            $display("FAIL write_apb_phases psel_cycles=%0d penable_cycles=%0d exp 3/2", ps, pe);
        end
        checks++;
        if (st !== 4'hF || wr !== 1'b1) begin
            failures++;
            $display("FAIL write_ctl pstrb=%h pwrite=%b exp f/1", st, wr);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_slave_mem got=%h exp=deadbeef", mem[4]);
        end
    endtask

    task automatic test_read();
        int lat, ps, pe;
        logic [3:0] st;
        logic wr;
        exp_q.push_back({2'b01, ref_mem[4]});
        wb_xfer(32'h10, 1'b0, 32'h0, 4'hF, lat, ps, pe, st, wr);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL read_latency got=%0d exp=4", lat); end
        checks++;
        if (st !== 4'h0 || wr !== 1'b0) begin
            failures++;
            $display("FAIL read_ctl pstrb=%h pwrite=%b exp 0/0", st, wr);
        end
    endtask

    task automatic test_slverr();
        int lat, ps, pe;
        logic [3:0] st;
        logic wr;
        slv_err = 1'b1;
        exp_q.push_back({2'b10, 32'h0});
        wb_xfer(32'h20, 1'b0, 32'h0, 4'hF, lat, ps, pe, st, wr);
        slv_err = 1'b0;
        checks++;
        if (lat != 4) begin failures++; $display("FAIL slverr_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_timeout();
        int lat, ps, pe;
        logic [3:0] st;
        logic wr;
        slv_stall = 1'b1;
        exp_q.push_back({2'b10, 32'h0});
        wb_xfer(32'h30, 1'b0, 32'h0, 4'hF, lat, ps, pe, st, wr);
        slv_stall = 1'b0;
        checks++;
        if (lat != 18) begin failures++; $display("FAIL timeout_latency got=%0d exp=18", lat); end
        checks++;
        if (pe != 16 || ps != 17) begin
            failures++;
            $display("FAIL timeout_access_cycles penable=%0d psel=%0d exp 16/17", pe, ps);
        end
        exp_q.push_back({2'b01, 32'h0});
        ref_mem[12] = 32'h1234_5678;
        wb_xfer(32'h30, 1'b1, 32'h1234_5678, 4'hF, lat, ps, pe, st, wr);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL timeout_recover_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_misalign();
        int lat, ps, pe;
        logic [3:0] st;
        logic wr;
        exp_q.push_back({2'b10, 32'h0});
        wb_xfer(32'h13, 1'b1, 32'hCAFE_F00D, 4'hF, lat, ps, pe, st, wr);
        checks++;
        if (lat != 1 || ps != 0) begin
            failures++;
            $display("FAIL misalign latency=%0d psel_cycles=%0d exp 1/0", lat, ps);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ps, pe;
        logic [3:0] st;
        logic wr;
        logic [31:0] adr, dat;
        logic [3:0] sel;
        logic we;
        int idx;
        for (int n = 0; n < 12; n++) begin
            slv_fast = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            adr = 32'(idx * 4);
            dat = $urandom;
            sel = 4'($urandom_range(0, 15));
            we  = 1'($urandom_range(0, 1));
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
                exp_q.push_back({2'b01, 32'h0});
            end else begin
                exp_q.push_back({2'b01, ref_mem[idx]});
            end
            wb_xfer(adr, we, dat, sel, lat, ps, pe, st, wr);
            checks++;
            if (lat != (slv_fast ? 3 : 4)) begin
                failures++;
                $display("FAIL b2b_latency n=%0d fast=%b got=%0d exp=%0d", n, slv_fast, lat,
                         slv_fast ? 3 : 4);
            end
        end
        slv_fast = 1'b0;
    endtask

    task automatic test_cyc_drop();
        int lat, ps, pe, n;
        logic [3:0] st;
        logic wr;
        logic resp;
        exp_q.push_back({2'b01, ref_mem[4]});
        wb_xfer(32'h10, 1'b0, 32'h0, 4'hF, lat, ps, pe, st, wr);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h40; wb_dat_i = 32'hA5A5_0F0F; wb_sel_i = 4'hF;
        n = 0;
        while (!penable && n < 10) begin @(negedge clk); n++; end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        checks++;
        if (penable !== 1'b1) begin failures++; $display("FAIL cyc_drop_access penable=%b exp 1", penable); end
        resp = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) resp = 1'b1;
        end
        checks++;
        if (resp !== 1'b0) begin failures++; $display("FAIL cyc_drop_response got=%b exp 0", resp); end
        checks++;
        if (mem[16] !== 32'hA5A5_0F0F) begin
            failures++;
            $display("FAIL cyc_drop_apb_done mem=%h exp=a5a50f0f", mem[16]);
        end
        checks++;
        if (wb_dat_o !== ref_mem[4]) begin
            failures++;
            $display("FAIL cyc_drop_dat_hold got=%h exp=%h", wb_dat_o, ref_mem[4]);
        end
        checks++;
        if (psel !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL cyc_drop_idle psel=%b state=%0d exp 0/%0d", psel, dbg_state, IDLE);
        end
        ref_mem[16] = 32'hA5A5_0F0F;
        exp_q.push_back({2'b01, ref_mem[16]});
        wb_xfer(32'h40, 1'b0, 32'h0, 4'hF, lat, ps, pe, st, wr);
    endtask

    task automatic test_reset_mid();
        int lat, ps, pe, n;
        logic [3:0] st;
        logic wr;
        slv_stall = 1'b1;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h50; wb_dat_i = 32'h0BAD_F00D; wb_sel_i = 4'hF;
        n = 0;
        while (!penable && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (penable !== 1'b1) begin failures++; $display("FAIL rst_mid_access penable=%b exp 1", penable); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async psel=%b penable=%b exp 0/0", psel, penable);
        end
        checks++;
        if (dbg_state !== IDLE || paddr !== 32'h0 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs state=%0d paddr=%h ack=%b err=%b exp %0d/0/0/0",
                     dbg_state, paddr, wb_ack_o, wb_err_o, IDLE);
        end
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; slv_stall = 1'b0; rst = 1'b0;
        // The slave model shares rst, so its storage restarts from zero too.
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        exp_q.push_back({2'b01, 32'h0});
        ref_mem[20] = 32'h0BAD_F00D;
        wb_xfer(32'h50, 1'b1, 32'h0BAD_F00D, 4'hF, lat, ps, pe, st, wr);
        checks++;
        if (lat != 4) begin failures++; $display("FAIL rst_mid_recover_latency got=%0d exp=4", lat); end
        exp_q.push_back({2'b01, ref_mem[20]});
        wb_xfer(32'h50, 1'b0, 32'h0, 4'hF, lat, ps, pe, st, wr);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_write();
        test_read();
        test_slverr();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_cyc_drop();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover entries=%0d exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
